// File: rtl/jk_cnt_pkg.sv
// Shared JK command encoding and steering helpers for the jk_mod_counter bit cells.
// Commands are packed as {J, K} so a cell can take cmd[1] as J and cmd[0] as K.
package jk_cnt_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    typedef enum logic [1:0] {
        MODE_HOLD,
        MODE_LOAD,
        MODE_COUNT
    } cnt_mode_e;

    // Counting only ever toggles or holds a bit; set/reset is reserved for loads.
    function automatic logic [1:0] jk_cmd(input logic cur, input logic nxt);
        return (cur ^ nxt) ? JK_TGL : JK_HOLD;
    endfunction

    function automatic logic [1:0] jk_load_cmd(input logic val);
        return val ? JK_SET : JK_RST;
    endfunction

endpackage

// File: rtl/jk_bit_cell.sv
// Single JK flip-flop storage cell with asynchronous active-high reset to q=0.
module jk_bit_cell
    import jk_cnt_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    logic q_q;
    logic q_d;

    always_comb begin
        // NOTE: default assignment first so every path drives q_d and no latch is inferred.
        q_d = q_q;
        case ({j, k})
            JK_RST:  q_d = 1'b0;
            JK_SET:  q_d = 1'b1;
            JK_TGL:  q_d = ~q_q;
            default: q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignment keeps all flops updating from pre-edge values.
        if (rst) q_q <= 1'b0;
        else     q_q <= q_d;
    end

    assign q     = q_q;
    assign q_bar = ~q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Loadable up/down modulo-MOD counter built from WIDTH JK bit cells.
// Define JK_MOD_COUNTER_SATURATE_EN to hold at the limits instead of wrapping.
module jk_mod_counter
    import jk_cnt_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_n,
    output logic             tc,
    output logic             load_err
);

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] CNT_MAX = (WIDTH)'(MOD - 1);

    logic [WIDTH:0]        cnt_ext;
    logic [WIDTH:0]        next_ext;
    logic                  at_max;
    logic                  at_zero;
    logic                  load_ok;
    cnt_mode_e             mode;
    logic [WIDTH-1:0][1:0] cell_cmd;
    logic                  load_err_q;
    logic                  load_err_d;
    logic                  unused_carry;

    assign cnt_ext = {1'b0, count};
    assign at_max  = (count == CNT_MAX);
    assign at_zero = (count == '0);
    assign load_ok = ({1'b0, load_val} < MOD_EXT);

    // Extra top bit absorbs the increment carry; only the low WIDTH bits steer cells.
    always_comb begin
        next_ext = cnt_ext;
        if (up) begin
            if (at_max) begin
`ifdef JK_MOD_COUNTER_SATURATE_EN
                next_ext = cnt_ext;
`else
                next_ext = '0;
`endif
            end else begin
                next_ext = cnt_ext + (WIDTH+1)'(1);
            end
        end else begin
            if (at_zero) begin
`ifdef JK_MOD_COUNTER_SATURATE_EN
                next_ext = cnt_ext;
`else
                next_ext = {1'b0, CNT_MAX};
`endif
            end else begin
                next_ext = cnt_ext - (WIDTH+1)'(1);
            end
        end
    end

    assign unused_carry = next_ext[WIDTH];

    // A rejected load wins over en and freezes every cell.
    always_comb begin
        mode = MODE_HOLD;
        if (load) begin
            mode = load_ok ? MODE_LOAD : MODE_HOLD;
        end else if (en) begin
            mode = MODE_COUNT;
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            cell_cmd[i] = JK_HOLD;
            case (mode)
                MODE_LOAD:  cell_cmd[i] = jk_load_cmd(load_val[i]);
                MODE_COUNT: cell_cmd[i] = jk_cmd(count[i], next_ext[i]);
                default:    cell_cmd[i] = JK_HOLD;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_bit_cell u_cell (
            .clk   (clk),
            .rst   (rst),
            .j     (cell_cmd[i][1]),
            .k     (cell_cmd[i][0]),
            .q     (count[i]),
            .q_bar (count_n[i])
        );
    end

    assign tc = en & ~load & (up ? at_max : at_zero);

    assign load_err_d = load & ~load_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) load_err_q <= 1'b0;
        else     load_err_q <= load_err_d;
    end

    assign load_err = load_err_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter (WIDTH=4, MOD=10): stimulus queues expected
// per-cycle state, a negedge monitor pops and compares.
module tb_jk_mod_counter;

`ifdef JK_MOD_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] count;
    logic [3:0] count_n;
    logic       tc;
    logic       load_err;

    typedef struct {
        logic [3:0] cnt;
        logic       tc;
        logic       err;
        int         id;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   row_id = 0;

    jk_mod_counter #(.WIDTH(4), .MOD(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .count_n  (count_n),
        .tc       (tc),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One row = inputs applied for one cycle plus the state expected during that cycle.
    task automatic row(input logic ld, input logic e, input logic u, input logic [3:0] lv,
                       input logic [3:0] ec, input logic etc, input logic eerr);
        @(posedge clk);
        #1;
        load     = ld;
        en       = e;
        up       = u;
        load_val = lv;
        sb_q.push_back('{ec, etc, eerr, row_id});
        row_id++;
    endtask

    initial begin : monitor
        exp_t       e;
        logic [3:0] exp_n;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e     = sb_q.pop_front();
                exp_n = ~e.cnt;
                check($sformatf("row%0d count", e.id), 32'(count), 32'(e.cnt));
                check($sformatf("row%0d count_n", e.id), 32'(count_n), 32'(exp_n));
                check($sformatf("row%0d tc", e.id), 32'(tc), 32'(e.tc));
                check($sformatf("row%0d load_err", e.id), 32'(load_err), 32'(e.err));
                check($sformatf("row%0d in_range", e.id), 32'(count < 4'd10), 32'd1);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        #2;
        check("por count", 32'(count), 32'd0);
        check("por count_n", 32'(count_n), 32'hF);
        check("por load_err", 32'(load_err), 32'd0);
        #5 rst = 1'b0;

        // Reach 7 with a pending rejected-load flag, then reset between edges.
        row(1, 0, 0, 4'd7,  4'd0, 0, 0);
        row(1, 0, 0, 4'd13, 4'd7, 0, 0);
        @(posedge clk);
        #1;
        load = 1'b1; en = 1'b0; load_val = 4'd3;
        #2;
        check("pre_rst count", 32'(count), 32'd7);
        check("pre_rst load_err", 32'(load_err), 32'd1);
        rst = 1'b1;
        #1;
        check("rst count", 32'(count), 32'd0);
        check("rst count_n", 32'(count_n), 32'hF);
        check("rst load_err", 32'(load_err), 32'd0);
        @(posedge clk);
        #2;
        check("rst_held count", 32'(count), 32'd0);
        rst = 1'b0;

        // First edge after release loads 3.
        row(1, 0, 0, 4'd0, 4'd3, 0, 0);

        // Count up 12 edges from 0 with wrap at 9.
        for (int i = 0; i < 12; i++) begin
            row(0, 1, 1, 4'd0, 4'(i % 10), (i % 10) == 9, 0);
        end

        // Count down 4 edges from 2.
        row(0, 1, 0, 4'd0, 4'd2, 0, 0);
        row(0, 1, 0, 4'd0, 4'd1, 0, 0);
        row(0, 1, 0, 4'd0, 4'd0, 1, 0);
        row(0, 1, 0, 4'd0, 4'd9, 0, 0);

        // Load accepted over en, then rejected load with en high.
        row(1, 1, 0, 4'd6,  4'd8, 0, 0);
        row(1, 1, 1, 4'd12, 4'd6, 0, 0);
        row(0, 0, 1, 4'd0,  4'd6, 0, 1);
        row(1, 0, 0, 4'd5,  4'd6, 0, 0);

        // Hold with en low, then alternate direction every edge.
        row(0, 0, 1, 4'd0, 4'd5, 0, 0);
        row(0, 0, 0, 4'd0, 4'd5, 0, 0);
        row(0, 0, 1, 4'd0, 4'd5, 0, 0);
        row(0, 1, 1, 4'd0, 4'd5, 0, 0);
        row(0, 1, 0, 4'd0, 4'd6, 0, 0);
        row(0, 1, 1, 4'd0, 4'd5, 0, 0);
        row(0, 1, 0, 4'd0, 4'd6, 0, 0);

        // Load boundaries: MOD-1 accepted, MOD rejected.
        row(1, 0, 0, 4'd9,  4'd5, 0, 0);
        row(1, 0, 0, 4'd10, 4'd9, 0, 0);
        row(0, 0, 1, 4'd0,  4'd9, 0, 1);
        row(0, 1, 1, 4'd0,  4'd9, 1, 0);
        row(0, 0, 1, 4'd0,  SAT ? 4'd9 : 4'd0, 0, 0);

        // Limits from 8 upward and from 1 downward (wrap or saturate).
        row(1, 0, 0, 4'd8, SAT ? 4'd9 : 4'd0, 0, 0);
        row(0, 1, 1, 4'd0, 4'd8, 0, 0);
        row(0, 1, 1, 4'd0, 4'd9, 1, 0);
        row(0, 1, 1, 4'd0, SAT ? 4'd9 : 4'd0, SAT, 0);
        row(1, 0, 0, 4'd1, SAT ? 4'd9 : 4'd1, 0, 0);
        row(0, 1, 0, 4'd0, 4'd1, 0, 0);
        row(0, 1, 0, 4'd0, 4'd0, 1, 0);
        row(0, 1, 0, 4'd0, SAT ? 4'd0 : 4'd9, SAT, 0);
        row(0, 0, 0, 4'd0, SAT ? 4'd0 : 4'd8, 0, 0);

        @(negedge clk);
        @(negedge clk);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
